// File: rtl/sd_spi_byte_xfer.sv
// sd_spi_byte_xfer
// SPI mode-0 (CPOL=0, CPHA=0) byte shifter sitting between the SD command/init
// FSM and the card pins. One byte is accepted per valid/ready handshake, shifted
// MSB-first on sd_cmd while 8 bits are captured from sd_data, and the captured
// byte is returned with a single-cycle rx_valid pulse. Chip select lives in the
// command FSM, not here.
//
// Timing of one byte (H = half period latched at accept):
//   accept edge -> LOW (H cycles) -> HIGH (H cycles) -> ... x8 bits -> DONE (1)
//   rx_valid / tx_ready rise 16*H+1 edges after the accept edge.
// MISO is sampled on the same clk edge that raises sd_cclk, i.e. one full
// half-period after sd_cmd was presented, which is what gives the card its
// setup margin. sd_data is deliberately not synchronised.

module sd_spi_byte_xfer #(
  parameter int CLK_DIVIDER_SLOW = 250,
  parameter int CLK_DIVIDER_FAST = 4,
  parameter int CNT_W            = 21
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       fast_mode,
  input  logic       tx_valid,
  input  logic [7:0] tx_data,
  output logic       tx_ready,
  output logic       rx_valid,
  output logic [7:0] rx_data,
  output logic       busy,
  output logic       sd_cclk,
  output logic       sd_cmd,
  input  logic       sd_data
);

  // Half periods derived from the dividers; a divider below 2 would give a
  // zero half period, which is clamped to one clk cycle.
  localparam int HALF_SLOW_I = ((CLK_DIVIDER_SLOW >> 1) < 1) ? 1 : (CLK_DIVIDER_SLOW >> 1);
  localparam int HALF_FAST_I = ((CLK_DIVIDER_FAST >> 1) < 1) ? 1 : (CLK_DIVIDER_FAST >> 1);

  localparam logic [CNT_W-1:0] HALF_SLOW = CNT_W'(HALF_SLOW_I);
  localparam logic [CNT_W-1:0] HALF_FAST = CNT_W'(HALF_FAST_I);

  // FSM encoding
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_LOW  = 2'd1;
  localparam logic [1:0] S_HIGH = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  // Control state
  logic [1:0]       state_q,   state_d;
  logic [CNT_W-1:0] cnt_q,     cnt_d;
  logic [CNT_W-1:0] half_q,    half_d;
  logic [2:0]       bit_idx_q, bit_idx_d;

  // Datapath state
  // Only the 7 bits still to be sent are kept; bit 7 goes straight to sd_cmd
  // at accept time.
  logic [6:0]       tx_shift_q, tx_shift_d;
  logic [7:0]       rx_shift_q, rx_shift_d;
  logic [7:0]       rx_data_q,  rx_data_d;
  logic             rx_valid_q, rx_valid_d;
  logic             sclk_q,     sclk_d;
  logic             cmd_q,      cmd_d;

  logic             half_end;
  logic             last_bit;

  // End of the current half period of sd_cclk
  always_comb begin
    half_end = (cnt_q == (half_q - CNT_W'(1)));
    last_bit = (bit_idx_q == 3'd7);
  end

  // Next-state logic for the FSM, the half-period counter and both shifters
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    half_d     = half_q;
    bit_idx_d  = bit_idx_q;
    tx_shift_d = tx_shift_q;
    rx_shift_d = rx_shift_q;
    rx_data_d  = rx_data_q;
    rx_valid_d = 1'b0;
    sclk_d     = sclk_q;
    cmd_d      = cmd_q;

    case (state_q)
      S_IDLE: begin
        // tx_ready is exactly "state is IDLE", so tx_valid alone accepts here.
        // fast_mode is only looked at now; later changes have no effect.
        if (tx_valid) begin
          tx_shift_d = tx_data[6:0];
          cmd_d      = tx_data[7];
          bit_idx_d  = 3'd0;
          cnt_d      = '0;
          half_d     = fast_mode ? HALF_FAST : HALF_SLOW;
          state_d    = S_LOW;
        end
      end

      S_LOW: begin
        if (half_end) begin
          // Rising edge of sd_cclk: capture MISO on this same clk edge.
          sclk_d     = 1'b1;
          rx_shift_d = {rx_shift_q[6:0], sd_data};
          cnt_d      = '0;
          state_d    = S_HIGH;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      S_HIGH: begin
        if (half_end) begin
          // Falling edge of sd_cclk: the only place sd_cmd may change.
          sclk_d = 1'b0;
          cnt_d  = '0;
          if (last_bit) begin
            cmd_d   = 1'b1;
            state_d = S_DONE;
          end else begin
            bit_idx_d  = bit_idx_q + 3'd1;
            cmd_d      = tx_shift_q[6];
            tx_shift_d = {tx_shift_q[5:0], 1'b0};
            state_d    = S_LOW;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      S_DONE: begin
        rx_data_d  = rx_shift_q;
        rx_valid_d = 1'b1;
        state_d    = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Control registers; an asserted reset aborts any byte in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      half_q    <= HALF_SLOW;
      bit_idx_q <= 3'd0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      half_q    <= half_d;
      bit_idx_q <= bit_idx_d;
    end
  end

  // Datapath and pin registers; pins return to their idle levels on reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_shift_q <= '0;
      rx_shift_q <= '0;
      rx_data_q  <= 8'h00;
      rx_valid_q <= 1'b0;
      sclk_q     <= 1'b0;
      cmd_q      <= 1'b1;
    end else begin
      tx_shift_q <= tx_shift_d;
      rx_shift_q <= rx_shift_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
      sclk_q     <= sclk_d;
      cmd_q      <= cmd_d;
    end
  end

  // Output mapping; ready/busy are combinational from the state
  always_comb begin
    tx_ready = (state_q == S_IDLE);
    busy     = (state_q != S_IDLE);
    rx_valid = rx_valid_q;
    rx_data  = rx_data_q;
    sd_cclk  = sclk_q;
    sd_cmd   = cmd_q;
  end

endmodule

// File: tb/tb_sd_spi_byte_xfer.sv
// Testbench for sd_spi_byte_xfer: a cycle-level reference model of the byte
// transfer (expressed as edge count since accept) is compared with the DUT on
// every clock, plus directed tests with hand-computed expectations.

module tb_sd_spi_byte_xfer;

  // Half periods at 100 MHz: 250/2 and 4/2
  localparam int HS = 125;
  localparam int HF = 2;

  logic       clk       = 1'b0;
  logic       rst_n     = 1'b0;
  logic       fast_mode = 1'b0;
  logic       tx_valid  = 1'b0;
  logic [7:0] tx_data   = 8'h00;
  logic       tx_ready;
  logic       rx_valid;
  logic [7:0] rx_data;
  logic       busy;
  logic       sd_cclk;
  logic       sd_cmd;
  logic       sd_data;

  // Card side: either MISO looped back to MOSI, or a card returning card_byte
  // MSB-first, advancing one bit after each rising sd_cclk.
  logic       loop_mode = 1'b1;
  logic [7:0] card_byte = 8'h00;
  int         card_cnt  = 0;
  int         card_base = 0;
  logic [2:0] card_idx;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  sd_spi_byte_xfer #(
    .CLK_DIVIDER_SLOW (250),
    .CLK_DIVIDER_FAST (4),
    .CNT_W            (21)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .fast_mode (fast_mode),
    .tx_valid  (tx_valid),
    .tx_data   (tx_data),
    .tx_ready  (tx_ready),
    .rx_valid  (rx_valid),
    .rx_data   (rx_data),
    .busy      (busy),
    .sd_cclk   (sd_cclk),
    .sd_cmd    (sd_cmd),
    .sd_data   (sd_data)
  );

  assign card_idx = 3'(7 - (card_cnt - card_base));
  assign sd_data  = loop_mode ? sd_cmd : card_byte[card_idx];

  always @(posedge sd_cclk) card_cnt <= card_cnt + 1;

  // Reference model: a byte occupies 16*H+1 edges after its accept edge.
  // After k edges (k < 16*H) the clock is in half period k/H, which is high
  // when odd, and bit k/(2H) is on MOSI. MISO is captured at each k where
  // a high half period begins.
  logic       m_busy = 1'b0;
  int         m_k    = 0;
  int         m_h    = 1;
  logic [7:0] m_d    = 8'h00;
  logic [7:0] m_cap  = 8'h00;
  logic [7:0] m_rxd  = 8'h00;
  logic       m_rxv  = 1'b0;

  // Model advance on each clock edge, or abort on reset
  always @(posedge clk or negedge rst_n) begin : model
    int         nk;
    logic [7:0] ncap;
    if (!rst_n) begin
      m_busy <= 1'b0;
      m_k    <= 0;
      m_rxv  <= 1'b0;
      m_rxd  <= 8'h00;
      m_cap  <= 8'h00;
    end else begin
      m_rxv <= 1'b0;
      if (m_busy) begin
        nk   = m_k + 1;
        ncap = m_cap;
        if (nk < 16 * m_h && (nk % m_h) == 0 && ((nk / m_h) % 2) == 1)
          ncap = {m_cap[6:0], sd_data};
        m_k   <= nk;
        m_cap <= ncap;
        if (nk == 16 * m_h + 1) begin
          m_busy <= 1'b0;
          m_rxv  <= 1'b1;
          m_rxd  <= ncap;
        end
      end else if (tx_valid) begin
        m_busy <= 1'b1;
        m_k    <= 0;
        m_h    <= fast_mode ? HF : HS;
        m_d    <= tx_data;
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Compare every DUT output against the model
  task automatic compare_all();
    logic exp_cclk;
    logic exp_cmd;
    exp_cclk = 1'b0;
    exp_cmd  = 1'b1;
    if (m_busy && m_k < 16 * m_h) begin
      exp_cclk = ((m_k / m_h) % 2) == 1;
      exp_cmd  = m_d[7 - m_k / (2 * m_h)];
    end
    chk("m_cclk",     32'(sd_cclk),  32'(exp_cclk));
    chk("m_cmd",      32'(sd_cmd),   32'(exp_cmd));
    chk("m_busy",     32'(busy),     32'(m_busy));
    chk("m_tx_ready", 32'(tx_ready), 32'(!m_busy));
    chk("m_rx_valid", 32'(rx_valid), 32'(m_rxv));
    chk("m_rx_data",  32'(rx_data),  32'(m_rxd));
  endtask

  // One clock: wait for the edge, then compare 1 ns later
  task automatic tick();
    @(posedge clk);
    #1;
    compare_all();
  endtask

  // Send one byte from idle; reports edges from accept to rx_valid, the
  // captured byte, cclk-high cycles and cclk rising edges. At edge tamper_at
  // (0 = never) fast_mode and tx_data are flipped to prove they are ignored.
  task automatic xfer(input logic [7:0] d, input logic fm, input int tamper_at,
                      output int lat, output logic [7:0] rx, output int hi, output int rises);
    logic prev;
    int   n;
    prev  = 1'b0;
    n     = 0;
    lat   = -1;
    rx    = 8'h00;
    hi    = 0;
    rises = 0;
    tx_data   = d;
    fast_mode = fm;
    tx_valid  = 1'b1;
    tick();
    tx_valid = 1'b0;
    while (n < 5000 && lat < 0) begin
      tick();
      n++;
      if (sd_cclk === 1'b1) begin
        hi++;
        if (!prev) rises++;
      end
      prev = sd_cclk;
      if (rx_valid === 1'b1) begin
        lat = n;
        rx  = rx_data;
      end
      if (n == tamper_at) begin
        fast_mode = ~fm;
        tx_data   = ~d;
      end
    end
    $display("xfer tx=%02h fast=%0d -> rx=%02h latency=%0d hi=%0d rises=%0d", d, fm, rx, lat, hi, rises);
  endtask

  initial begin : main
    int         lat, hi, rises, n, p1, p2, cnt;
    logic [7:0] rx, r1, r2;

    // Reset state
    repeat (3) tick();
    chk("rst_tx_ready", 32'(tx_ready), 32'd1);
    chk("rst_busy",     32'(busy),     32'd0);
    chk("rst_cclk",     32'(sd_cclk),  32'd0);
    chk("rst_cmd",      32'(sd_cmd),   32'd1);
    chk("rst_rx_valid", 32'(rx_valid), 32'd0);
    chk("rst_rx_data",  32'(rx_data),  32'h00);
    rst_n = 1'b1;
    repeat (3) tick();

    // 1: fast, loopback A5
    loop_mode = 1'b1;
    xfer(8'hA5, 1'b1, 0, lat, rx, hi, rises);
    chk("t1_latency", 32'(lat),   32'd33);
    chk("t1_rx",      32'(rx),    32'hA5);
    chk("t1_pulses",  32'(rises), 32'd8);
    chk("t1_hi",      32'(hi),    32'd16);
    repeat (2) tick();

    // 2: slow, card returns 01 while host sends FF
    loop_mode = 1'b0;
    card_byte = 8'h01;
    card_base = card_cnt;
    xfer(8'hFF, 1'b0, 0, lat, rx, hi, rises);
    chk("t2_latency", 32'(lat),   32'd2001);
    chk("t2_rx",      32'(rx),    32'h01);
    chk("t2_pulses",  32'(rises), 32'd8);
    chk("t2_hi",      32'(hi),    32'd1000);
    loop_mode = 1'b1;
    repeat (2) tick();

    // 3: back-to-back with tx_valid held: 40 then 00
    tx_data   = 8'h40;
    fast_mode = 1'b1;
    tx_valid  = 1'b1;
    tick();
    tx_data = 8'h00;
    n  = 0;
    p1 = -1;
    p2 = -1;
    r1 = 8'h00;
    r2 = 8'h00;
    while (n < 200 && p2 < 0) begin
      tick();
      n++;
      if (rx_valid === 1'b1) begin
        if (p1 < 0) begin
          p1 = n;
          r1 = rx_data;
          chk("t3_gap_cmd",  32'(sd_cmd),  32'd1);
          chk("t3_gap_cclk", 32'(sd_cclk), 32'd0);
        end else begin
          p2 = n;
          r2 = rx_data;
        end
      end
      if (p1 >= 0 && n == p1 + 1) tx_valid = 1'b0;
    end
    tx_valid = 1'b0;
    $display("b2b rx1=%02h at %0d rx2=%02h at %0d", r1, p1, r2, p2);
    chk("t3_first_lat", 32'(p1),      32'd33);
    chk("t3_spacing",   32'(p2 - p1), 32'd34);
    chk("t3_rx1",       32'(r1),      32'h40);
    chk("t3_rx2",       32'(r2),      32'h00);
    repeat (2) tick();

    // 4: reset 10 edges into a fast byte
    tx_data   = 8'h96;
    fast_mode = 1'b1;
    tx_valid  = 1'b1;
    tick();
    tx_valid = 1'b0;
    repeat (10) tick();
    chk("t4_busy_before", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("t4_rst_cclk",     32'(sd_cclk),  32'd0);
    chk("t4_rst_cmd",      32'(sd_cmd),   32'd1);
    chk("t4_rst_ready",    32'(tx_ready), 32'd1);
    chk("t4_rst_rx_valid", 32'(rx_valid), 32'd0);
    $display("reset mid-byte: cclk=%0d cmd=%0d ready=%0d", sd_cclk, sd_cmd, tx_ready);
    tick();
    tick();
    rst_n = 1'b0;
    rst_n = 1'b1;
    cnt = 0;
    repeat (40) begin
      tick();
      if (rx_valid !== 1'b0) cnt++;
    end
    chk("t4_no_rx_valid", 32'(cnt), 32'd0);
    xfer(8'h3C, 1'b1, 0, lat, rx, hi, rises);
    chk("t4_latency", 32'(lat), 32'd33);
    chk("t4_rx",      32'(rx),  32'h3C);
    repeat (2) tick();

    // 5: slow byte with fast_mode and tx_data flipped mid-byte
    xfer(8'h5A, 1'b0, 300, lat, rx, hi, rises);
    chk("t5_latency", 32'(lat),   32'd2001);
    chk("t5_rx",      32'(rx),    32'h5A);
    chk("t5_hi",      32'(hi),    32'd1000);
    chk("t5_pulses",  32'(rises), 32'd8);

    // 6: long idle
    fast_mode = 1'b0;
    tx_valid  = 1'b0;
    cnt = 0;
    repeat (1000) begin
      tick();
      if (sd_cclk !== 1'b0 || sd_cmd !== 1'b1 || rx_valid !== 1'b0) cnt++;
    end
    chk("t6_idle_quiet", 32'(cnt), 32'd0);
    $display("idle 1000 cycles: deviations=%0d", cnt);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
